// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory request/response, execute redirect
// and the valid/ready handoff to decode.
interface instr_fetch_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;

  // Fetch-stage side.
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_target,
    output if_valid, if_instr, if_pc,
    input  if_ready
  );

  // Memory / execute / decode side.
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_target,
    input  if_valid, if_instr, if_pc,
    output if_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage. Issues one instruction-memory read at a time for
// current_pc, hands the fetched word to decode over valid/ready, and drives
// the enable-less PC register's next_pc input (hold, advance or redirect).
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   current_pc,
  output logic [31:0]   next_pc,
  instr_fetch_if.master bus
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_KILL = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]  state_q;
  logic        if_valid_q;
  logic [31:0] if_instr_q;
  logic [31:0] if_pc_q;

  logic        req_valid;
  logic [31:0] redirect_pc;
  logic [31:0] seq_pc;
  logic        unused_tgt_lsb;

  assign redirect_pc    = {bus.redirect_target[31:2], 2'b00};
  assign seq_pc         = current_pc + 32'd4;
  assign unused_tgt_lsb = ^bus.redirect_target[1:0];

  // Request only from REQ, suppressed while reset is asserted or a redirect
  // is changing the PC this cycle.
  always_comb begin
    req_valid = 1'b0;
    if (reset && (state_q == S_REQ) && !bus.redirect_valid)
      req_valid = 1'b1;
  end

  // PC register input: reset, then redirect, then advance on an accepted
  // response in WAIT, otherwise hold.
  always_comb begin
    next_pc = current_pc;
    if (!reset)
      next_pc = RESET_PC;
    else if (bus.redirect_valid)
      next_pc = redirect_pc;
    else if ((state_q == S_WAIT) && bus.imem_resp_valid)
      next_pc = seq_pc;
  end

  // Fetch FSM and registered decode-side outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_REQ;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_valid && bus.imem_req_ready)
            state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.imem_resp_valid && !bus.redirect_valid) begin
            if_instr_q <= bus.imem_resp_data;
            if_pc_q    <= current_pc;
            if_valid_q <= 1'b1;
            state_q    <= S_HOLD;
          end else if (bus.redirect_valid && !bus.imem_resp_valid) begin
            state_q <= S_KILL;
          end else if (bus.redirect_valid && bus.imem_resp_valid) begin
            state_q <= S_REQ;
          end
        end
        S_KILL: begin
          // A redirect here only moves the PC; the stale response still
          // has to drain before a new request may go out.
          if (bus.imem_resp_valid)
            state_q <= S_REQ;
        end
        S_HOLD: begin
          if (bus.redirect_valid || bus.if_ready) begin
            if_valid_q <= 1'b0;
            state_q    <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = current_pc;
  assign bus.if_valid       = if_valid_q;
  assign bus.if_instr       = if_instr_q;
  assign bus.if_pc          = if_pc_q;

endmodule
